// File: rtl/store_buffer_pkg.sv
// Shared memory-side defines: access size encoding and default data/address width.
package store_buffer_pkg;

    localparam int SB_XLEN = 32;

    // Access size encoding shared by the store buffer and the data memories.
    typedef enum logic [1:0] {
        SZ_ILLEGAL = 2'b00,
        SZ_BYTE    = 2'b01,
        SZ_HALF    = 2'b10,
        SZ_WORD    = 2'b11
    } sb_size_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: payload array, head/tail pointers, occupancy count.
// Exposes per-entry word addresses and validity for the load hazard compare.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = SB_XLEN,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [XLEN-1:0]             push_addr,
    input  logic [XLEN-1:0]             push_data,
    input  logic [1:0]                  push_size,
    output logic [XLEN-1:0]             head_addr,
    output logic [XLEN-1:0]             head_data,
    output logic [1:0]                  head_size,
    output logic [DEPTH*(XLEN-2)-1:0]   ent_waddr,
    output logic [DEPTH-1:0]            ent_valid,
    output logic                        full,
    output logic                        empty
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [1:0]      size_q [DEPTH];
    logic [AW-1:0]   offset;

    // Pointer and count update; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_ONE;
        if (pop)  head_d = head_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared asynchronously so pending stores vanish at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload array; contents only matter where the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
            size_q[tail_q] <= push_size;
        end
    end

    // Entry i is valid when its distance from head is below the count.
    always_comb begin
        offset    = '0;
        ent_valid = '0;
        ent_waddr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = AW'(i) - head_q;
            ent_valid[i] = ({1'b0, offset} < count_q);
            ent_waddr[i*(XLEN-2) +: (XLEN-2)] = addr_q[i][XLEN-1:2];
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign head_size = size_q[head_q];
    assign full      = (count_q == CNT_MAX);
    assign empty     = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between pipeline and data memory. Loads own the memory port
// unless they hit a pending store's word; otherwise the oldest store drains.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = SB_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [1:0]      st_size,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    output logic            ld_stall,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    output logic [1:0]      mem_swhb,
    output logic [1:0]      mem_lwhb,
    output logic            mem_lu,
    output logic            empty
);

    // Handshake: a store transfers on a rising edge where st_valid and st_ready
    // are both high; an illegal size is acknowledged but never queued.

    logic [XLEN-1:0]          head_addr;
    logic [XLEN-1:0]          head_data;
    logic [1:0]               head_size;
    logic [DEPTH*(XLEN-2)-1:0] ent_waddr;
    logic [DEPTH-1:0]         ent_valid;
    logic                     full;
    logic                     fifo_empty;
    logic                     push;
    logic                     drain;
    logic                     hit;
    logic                     size_ok;

    sb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .pop       (drain),
        .push_addr (st_addr),
        .push_data (st_data),
        .push_size (st_size),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_size (head_size),
        .ent_waddr (ent_waddr),
        .ent_valid (ent_valid),
        .full      (full),
        .empty     (fifo_empty)
    );

    // Word-granular hazard compare against registered entries only.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_waddr[i*(XLEN-2) +: (XLEN-2)] == ld_addr[XLEN-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    // Arbitration: loads beat stores at the pipeline side and at the port.
    always_comb begin
        size_ok  = (st_size != SZ_ILLEGAL);
        ld_stall = ld_valid & hit;
        st_ready = !ld_valid && (!full || !size_ok);
        push     = st_valid && st_ready && size_ok;
        drain    = !fifo_empty && (!ld_valid || ld_stall);
    end

    // Memory port mux: unstalled load, else head-of-queue write, else all zero.
    always_comb begin
        mem_we   = 1'b0;
        mem_a    = '0;
        mem_wd   = '0;
        mem_swhb = 2'b00;
        mem_lwhb = 2'b00;
        mem_lu   = 1'b0;
        if (ld_valid && !ld_stall) begin
            mem_a    = ld_addr;
            mem_lwhb = ld_size;
            mem_lu   = ld_unsigned;
        end else if (drain) begin
            mem_we   = 1'b1;
            mem_a    = head_addr;
            mem_wd   = head_data;
            mem_swhb = head_size;
        end
    end

    assign empty = fifo_empty;

endmodule
